// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, driving datapath strobes and ALUOp.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [2:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  state_t     cur;
  logic [5:0] op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur  <= S_FETCH;
      op_q <= '0;
    end else begin
      case (cur)
        S_FETCH:  if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          op_q <= opcode;
          case (opcode)
            OP_RTYPE:                 cur <= S_EXEC;
            OP_LW, OP_SW:             cur <= S_MEMADR;
            OP_BEQ:                   cur <= S_BRANCH;
            OP_J:                     cur <= S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI: cur <= S_IEXEC;
            default:                  cur <= S_FETCH;
          endcase
        end
        S_MEMADR: cur <= (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) cur <= S_MEMWB;
        S_MEMWR:  if (mem_ready) cur <= S_FETCH;
        S_EXEC:   cur <= S_ALUWB;
        S_IEXEC:  cur <= S_IWB;
        default:  cur <= S_FETCH;
      endcase
    end
  end

  assign state = cur;

  // Outputs are gated by rst_n so FETCH strobes stay silent while reset is held.
  always_comb begin
    ALUOp       = '0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = '0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = '0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    if (rst_n) begin
      case (cur)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI: ;
            default: begin
              illegal    = 1'b1;
              instr_done = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 3'b010;
        end
        S_ALUWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 3'b001;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        S_IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          case (op_q)
            OP_ADDI: ALUOp = 3'b011;
            OP_ANDI: ALUOp = 3'b100;
            OP_ORI:  ALUOp = 3'b101;
            default: ALUOp = 3'b000;
          endcase
        end
        S_IWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
